// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sb_pkg
// Purpose : Shared definitions for the scoreboard instruction queue:
//           opcode constants, functional-unit codes, the opcode -> FU
//           decode function and the issue-FSM state encoding.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package sb_pkg;

   // Opcodes that route to a non-ALU functional unit
   localparam logic [2:0] OP_MUL = 3'd5;
   localparam logic [2:0] OP_DIV = 3'd6;

   // Functional-unit type codes (code 1 is reserved)
   localparam logic [1:0] FU_ALU = 2'd0;
   localparam logic [1:0] FU_MUL = 2'd2;
   localparam logic [1:0] FU_DIV = 2'd3;

   // Issue-side state: PRESENT offers the head, HOLD keeps the accepted
   // fields on the bus for the one cycle in which the scoreboard samples them.
   typedef enum logic [0:0] {
      IQ_PRESENT = 1'b0,
      IQ_HOLD    = 1'b1
   } iq_state_e;

   function automatic logic [1:0] op_to_fu(input logic [2:0] op);
      logic [1:0] fu;
      fu = FU_ALU;
      if (op == OP_MUL) begin
         fu = FU_MUL;
      end else if (op == OP_DIV) begin
         fu = FU_DIV;
      end
      return fu;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sb_iq_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sb_iq_fifo
// Purpose : Storage array, read/write pointers and occupancy count for the
//           instruction queue, with synchronous flush. Besides the full flag
//           it exports a look-ahead view (head word and empty flag as they
//           will be after the current edge) so the top can register its
//           outputs without adding a cycle of latency.
// Ports   : clk, rst_n        clock / async active-low reset
//           flush             clear pointers and count, drop same-cycle push
//           push, wdata       write request and data (ignored when full)
//           pop               remove the head entry (ignored when empty)
//           head_nxt          head word after this edge
//           empty_nxt         queue empty after this edge
//           full              queue holds DEPTH entries (registered count)
//           count             current occupancy
// Revision: 1.0  initial release
// ============================================================================
module sb_iq_fifo #(
   parameter int DEPTH    = 8,
   parameter int PTR_BITS = 3,
   parameter int WIDTH    = 20
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                push,
   input  logic [WIDTH-1:0]    wdata,
   input  logic                pop,
   output logic [WIDTH-1:0]    head_nxt,
   output logic                empty_nxt,
   output logic                full,
   output logic [PTR_BITS:0]   count
);

   localparam logic [PTR_BITS:0] C_DEPTH = (PTR_BITS+1)'(DEPTH);

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [PTR_BITS-1:0] r_wr_ptr;
   logic [PTR_BITS-1:0] r_rd_ptr;
   logic [PTR_BITS:0]   r_count;

   logic                w_push;
   logic                w_pop;
   logic [PTR_BITS-1:0] w_wr_ptr_nxt;
   logic [PTR_BITS-1:0] w_rd_ptr_nxt;
   logic [PTR_BITS:0]   w_count_pop;
   logic [PTR_BITS:0]   w_count_nxt;

   assign full  = (r_count == C_DEPTH);
   assign count = r_count;

   // Full blocks a push even when a pop frees a slot in the same cycle.
   assign w_push = push && !full && !flush;
   assign w_pop  = pop && (r_count != '0);

   assign w_count_pop  = r_count - (PTR_BITS+1)'(w_pop);
   assign w_count_nxt  = flush ? '0 : (w_count_pop + (PTR_BITS+1)'(w_push));
   assign w_wr_ptr_nxt = flush ? '0 : (r_wr_ptr + PTR_BITS'(w_push));
   assign w_rd_ptr_nxt = flush ? '0 : (r_rd_ptr + PTR_BITS'(w_pop));

   assign empty_nxt = (w_count_nxt == '0);

   // When nothing remains after the pop, the incoming word becomes the head.
   assign head_nxt = (w_push && (w_count_pop == '0)) ? wdata : r_mem[w_rd_ptr_nxt];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
      end
   end

   // Storage carries no reset; entries are only read once written.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sb_inst_queue.sv
`default_nettype none
// ============================================================================
// Module  : sb_inst_queue
// Purpose : In-order instruction queue feeding the scoreboard. Decodes the
//           FU type at push, offers one instruction at a time, honours the
//           scoreboard stall, holds the accepted fields for one extra cycle
//           and supports flush.
// Ports   : clk, rst_n                   clock / async active-low reset
//           flush                        discard queued, unaccepted entries
//           in_valid/in_ready            fetch handshake (in_ready = !full)
//           in_op, in_fi/fj/fk           incoming opcode and registers
//           inst_valid                   head offered to scoreboard
//           inst_op, inst_fi/fj/fk       offered opcode and registers
//           inst_fu_type                 0=ALU 2=MUL 3=DIV
//           stall                        scoreboard cannot issue
//           count                        occupancy (held entry excluded)
//           perf_stall_cyc, perf_issued  only with SB_IQ_PERF_CNT_EN
// Config  : `define SB_IQ_PERF_CNT_EN adds saturating 32-bit counters of
//           stalled-offer cycles and accepted instructions.
// Revision: 1.0  initial release
// ============================================================================
module sb_inst_queue
   import sb_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int PTR_BITS = 3,
   parameter int REG_BITS = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          in_op,
   input  logic [REG_BITS-1:0] in_fi,
   input  logic [REG_BITS-1:0] in_fj,
   input  logic [REG_BITS-1:0] in_fk,
   output logic                inst_valid,
   output logic [2:0]          inst_op,
   output logic [REG_BITS-1:0] inst_fi,
   output logic [REG_BITS-1:0] inst_fj,
   output logic [REG_BITS-1:0] inst_fk,
   output logic [1:0]          inst_fu_type,
   input  logic                stall,
   output logic [PTR_BITS:0]   count
`ifdef SB_IQ_PERF_CNT_EN
   ,
   output logic [31:0]         perf_stall_cyc,
   output logic [31:0]         perf_issued
`endif
);

   // Queue word: {fu_type, op, fi, fj, fk}
   localparam int C_WIDTH = 5 + 3*REG_BITS;

   logic [C_WIDTH-1:0]  w_wdata;
   logic [C_WIDTH-1:0]  w_head_nxt;
   logic                w_empty_nxt;
   logic                w_full;
   logic                w_accept;
   logic [1:0]          w_head_fu;
   logic [2:0]          w_head_op;
   logic [REG_BITS-1:0] w_head_fi;
   logic [REG_BITS-1:0] w_head_fj;
   logic [REG_BITS-1:0] w_head_fk;

   iq_state_e           r_state;
   logic                r_inst_valid;
   logic [2:0]          r_inst_op;
   logic [REG_BITS-1:0] r_inst_fi;
   logic [REG_BITS-1:0] r_inst_fj;
   logic [REG_BITS-1:0] r_inst_fk;
   logic [1:0]          r_inst_fu;

   assign w_wdata = {op_to_fu(in_op), in_op, in_fi, in_fj, in_fk};
   assign {w_head_fu, w_head_op, w_head_fi, w_head_fj, w_head_fk} = w_head_nxt;

   // inst_valid is only ever set in PRESENT, so this is the accept condition.
   assign w_accept = r_inst_valid && !stall;

   sb_iq_fifo #(
      .DEPTH    (DEPTH),
      .PTR_BITS (PTR_BITS),
      .WIDTH    (C_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (in_valid),
      .wdata     (w_wdata),
      .pop       (w_accept),
      .head_nxt  (w_head_nxt),
      .empty_nxt (w_empty_nxt),
      .full      (w_full),
      .count     (count)
   );

   assign in_ready = !w_full;

   // Issue FSM with registered outputs. Outputs are loaded from the FIFO
   // look-ahead so a push into an empty queue is visible the next cycle.
   // When the queue will be empty the fields keep their last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IQ_PRESENT;
         r_inst_valid <= 1'b0;
         r_inst_op    <= '0;
         r_inst_fi    <= '0;
         r_inst_fj    <= '0;
         r_inst_fk    <= '0;
         r_inst_fu    <= '0;
      end else begin
         case (r_state)
            IQ_PRESENT: begin
               if (w_accept) begin
                  // Accepted fields stay on the bus through HOLD.
                  r_state      <= IQ_HOLD;
                  r_inst_valid <= 1'b0;
               end else begin
                  r_inst_valid <= !w_empty_nxt;
                  if (!w_empty_nxt) begin
                     r_inst_op <= w_head_op;
                     r_inst_fi <= w_head_fi;
                     r_inst_fj <= w_head_fj;
                     r_inst_fk <= w_head_fk;
                     r_inst_fu <= w_head_fu;
                  end
               end
            end
            IQ_HOLD: begin
               r_state      <= IQ_PRESENT;
               r_inst_valid <= !w_empty_nxt;
               if (!w_empty_nxt) begin
                  r_inst_op <= w_head_op;
                  r_inst_fi <= w_head_fi;
                  r_inst_fj <= w_head_fj;
                  r_inst_fk <= w_head_fk;
                  r_inst_fu <= w_head_fu;
               end
            end
            default: begin
               r_state      <= IQ_PRESENT;
               r_inst_valid <= 1'b0;
            end
         endcase
      end
   end

   assign inst_valid   = r_inst_valid;
   assign inst_op      = r_inst_op;
   assign inst_fi      = r_inst_fi;
   assign inst_fj      = r_inst_fj;
   assign inst_fk      = r_inst_fk;
   assign inst_fu_type = r_inst_fu;

`ifdef SB_IQ_PERF_CNT_EN
   logic [31:0] r_perf_stall_cyc;
   logic [31:0] r_perf_issued;

   // Saturating counters; flush does not touch them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_stall_cyc <= '0;
         r_perf_issued    <= '0;
      end else begin
         if (r_inst_valid && stall && (r_perf_stall_cyc != 32'hFFFF_FFFF)) begin
            r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
         end
         if (w_accept && (r_perf_issued != 32'hFFFF_FFFF)) begin
            r_perf_issued <= r_perf_issued + 32'd1;
         end
      end
   end

   assign perf_stall_cyc = r_perf_stall_cyc;
   assign perf_issued    = r_perf_issued;
`endif

endmodule
`default_nettype wire
